// File: rtl/debug_frame_streamer.sv
// Debug frame streamer: snapshots a bus of channels and sends the enabled ones to a UART TX
// as one frame: a header byte, the payload bytes, then an optional XOR checksum byte.
module debug_frame_streamer #(
  parameter int                  WORD_BITS   = 32,
  parameter int                  NUM_WORDS   = 20,
  parameter int                  SIZE_TRAMA  = 8,
  parameter bit                  LSB_FIRST   = 1'b1,
  parameter logic [SIZE_TRAMA-1:0] HEADER_BYTE = 8'hA5,
  parameter bit                  CHECKSUM_EN = 1'b1
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic [NUM_WORDS*WORD_BITS-1:0]  i_words,
  input  logic [NUM_WORDS-1:0]            i_word_mask,
  input  logic                            i_tx_done,
  output logic                            o_tx_start,
  output logic [SIZE_TRAMA-1:0]           o_tx_data,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [15:0]                     o_frame_bytes
);

  localparam int BYTES = WORD_BITS / SIZE_TRAMA;
  localparam int CW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FIN} state_e;
  typedef enum logic [1:0] {P_HDR, P_PAY, P_SUM} phase_e;

  state_e                         state_q, state_d;
  phase_e                         phase_q, phase_d;
  logic [NUM_WORDS*WORD_BITS-1:0] words_q, words_d;
  logic [NUM_WORDS-1:0]           mask_q, mask_d;
  logic [CW-1:0]                  chan_q, chan_d;
  logic [BW-1:0]                  byte_q, byte_d;
  logic [SIZE_TRAMA-1:0]          data_q, data_d;
  logic [SIZE_TRAMA-1:0]          sum_q, sum_d;
  logic [15:0]                    count_q, count_d;
  logic [15:0]                    frame_q, frame_d;

  logic [CW:0]   search_from;
  logic          hit;
  logic [CW-1:0] hit_idx;
  logic          last_byte;

  function automatic logic [SIZE_TRAMA-1:0] pick(input logic [NUM_WORDS*WORD_BITS-1:0] w,
                                                 input logic [CW-1:0] ch,
                                                 input logic [BW-1:0] bi);
    int pos;
    pos = LSB_FIRST ? int'(bi) : BYTES - 1 - int'(bi);
    return w[int'(ch)*WORD_BITS + pos*SIZE_TRAMA +: SIZE_TRAMA];
  endfunction

  // Lowest enabled channel at or above search_from; disabled channels cost no cycles.
  always_comb begin
    search_from = (phase_q == P_HDR) ? '0 : {1'b0, chan_q} + 1'b1;
    hit         = 1'b0;
    hit_idx     = '0;
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (mask_q[k] && (k >= int'(search_from))) begin
        hit     = 1'b1;
        hit_idx = CW'(k);
      end
    end
  end

  assign last_byte = (byte_q == BW'(BYTES - 1));

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path leaves one unassigned (no latches).
    state_d = state_q;
    phase_d = phase_q;
    words_d = words_q;
    mask_d  = mask_q;
    chan_d  = chan_q;
    byte_d  = byte_q;
    data_d  = data_q;
    sum_d   = sum_q;
    count_d = count_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          words_d = i_words;
          mask_d  = i_word_mask;
          sum_d   = '0;
          count_d = '0;
          chan_d  = '0;
          byte_d  = '0;
          phase_d = P_HDR;
          data_d  = HEADER_BYTE;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          state_d = S_LOAD;
          if (phase_q == P_PAY && !last_byte) begin
            byte_d = byte_q + 1'b1;
            data_d = pick(words_q, chan_q, byte_q + 1'b1);
            sum_d  = sum_q ^ data_d;
          end else if (phase_q != P_SUM && hit) begin
            phase_d = P_PAY;
            chan_d  = hit_idx;
            byte_d  = '0;
            data_d  = pick(words_q, hit_idx, '0);
            sum_d   = sum_q ^ data_d;
          end else if (phase_q != P_SUM && CHECKSUM_EN) begin
            phase_d = P_SUM;
            data_d  = sum_q;
          end else begin
            state_d = S_FIN;
            frame_d = count_q;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      phase_q <= P_HDR;
      chan_q  <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      chan_q  <= chan_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      frame_q <= frame_d;
    end
  end

  // NOTE: the snapshot has no reset; it is always reloaded on i_start before any byte is read from it.
  always_ff @(posedge i_clk) begin
    words_q <= words_d;
    mask_q  <= mask_d;
  end

  assign o_tx_start    = (state_q == S_LOAD);
  assign o_busy        = (state_q == S_LOAD) || (state_q == S_WAIT);
  assign o_done        = (state_q == S_FIN);
  assign o_tx_data     = data_q;
  assign o_frame_bytes = frame_q;

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Bench for debug_frame_streamer: three instances (LSB-first+checksum, MSB-first+checksum,
// LSB-first without checksum) driven by a cycle-stepped UART model.
module tb_debug_frame_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] words;
  logic [2:0]  mask;
  logic        start_i   [3];
  logic        tx_done_i [3];
  logic        tx_start_o[3];
  logic [7:0]  tx_data_o [3];
  logic        busy_o    [3];
  logic        done_o    [3];
  logic [15:0] frame_o   [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    debug_frame_streamer #(
      .WORD_BITS(16), .NUM_WORDS(3), .SIZE_TRAMA(8),
      .LSB_FIRST(g != 1), .HEADER_BYTE(8'hA5), .CHECKSUM_EN(g != 2)
    ) u_dut (
      .i_clk(clk), .i_reset(rst), .i_start(start_i[g]),
      .i_words(words), .i_word_mask(mask), .i_tx_done(tx_done_i[g]),
      .o_tx_start(tx_start_o[g]), .o_tx_data(tx_data_o[g]),
      .o_busy(busy_o[g]), .o_done(done_o[g]), .o_frame_bytes(frame_o[g])
    );
  end

  typedef struct packed {
    int          dut;
    logic [2:0]  mask;
    int          gap;
    int          n;
    logic [63:0] b;   // expected bytes, first byte in bits [63:56]
  } vec_t;

  localparam logic [47:0] WORDS0 = {16'h00FF, 16'hABCD, 16'h1234};

  vec_t       vecs[7];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] got[16];
  int         r_n, r_dones, r_hold_err, r_lat_err, r_timeout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requests a frame on instance d and answers each o_tx_start with i_tx_done after gap cycles.
  task automatic run_frame(input int d, input int gap, input bit disturb, input int abort_byte);
    int wait_cnt, exp_at, post;
    logic [7:0] held;
    r_n = 0; r_dones = 0; r_hold_err = 0; r_lat_err = 0; r_timeout = 1;
    wait_cnt = 0; exp_at = 0; post = 0; held = '0;
    for (int i = 0; i < 16; i++) got[i] = '0;
    @(negedge clk); start_i[d] = 1'b1;
    @(negedge clk); start_i[d] = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      tx_done_i[d] = 1'b0;
      start_i[d]   = 1'b0;
      if (tx_start_o[d]) begin
        if (cyc != exp_at || !busy_o[d]) r_lat_err++;
        if (r_n < 16) got[r_n] = tx_data_o[d];
        r_n++;
        held     = tx_data_o[d];
        wait_cnt = gap;
        if (disturb && r_n == 3) begin
          start_i[d] = 1'b1;
          words      = ~words;
          mask       = ~mask;
        end
      end else if (wait_cnt > 0) begin
        if (tx_data_o[d] !== held) r_hold_err++;
        if (abort_byte != 0 && r_n == abort_byte && wait_cnt == gap - 1) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("abort_tx_start", tx_start_o[d], 0);
          check("abort_tx_data", tx_data_o[d], 0);
          check("abort_busy", busy_o[d], 0);
          check("abort_done", done_o[d], 0);
          check("abort_frame_bytes", frame_o[d], 0);
          repeat (20) begin
            @(negedge clk);
            if (tx_start_o[d]) r_n++;
            if (done_o[d]) r_dones++;
          end
          r_timeout = 0;
          return;
        end
        wait_cnt--;
        if (wait_cnt == 0) begin
          tx_done_i[d] = 1'b1;
          exp_at       = cyc + 1;
        end
      end
      if (done_o[d]) begin
        if (cyc != exp_at) r_lat_err++;
        r_dones++;
      end
      if (r_dones > 0) begin
        post++;
        if (post > 10) begin
          r_timeout = 0;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int d, input int n, input logic [63:0] b);
    logic [63:0] bb;
    bb = b;
    check({tag, "_count"}, r_n, n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], bb[63-8*i -: 8]);
    check({tag, "_frame_bytes"}, frame_o[d], n);
    check({tag, "_done_pulses"}, r_dones, 1);
    check({tag, "_latency_errs"}, r_lat_err, 0);
    check({tag, "_hold_errs"}, r_hold_err, 0);
    check({tag, "_timeout"}, r_timeout, 0);
    check({tag, "_busy_end"}, busy_o[d], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    vecs[0] = '{dut: 0, mask: 3'b111, gap: 5, n: 8, b: 64'hA5_34_12_CD_AB_FF_00_BF};
    vecs[1] = '{dut: 1, mask: 3'b010, gap: 5, n: 4, b: 64'hA5_AB_CD_66_00_00_00_00};
    vecs[2] = '{dut: 0, mask: 3'b000, gap: 5, n: 2, b: 64'hA5_00_00_00_00_00_00_00};
    vecs[3] = '{dut: 2, mask: 3'b000, gap: 5, n: 1, b: 64'hA5_00_00_00_00_00_00_00};
    vecs[4] = '{dut: 1, mask: 3'b101, gap: 2, n: 6, b: 64'hA5_12_34_00_FF_D9_00_00};
    vecs[5] = '{dut: 2, mask: 3'b110, gap: 1, n: 5, b: 64'hA5_CD_AB_FF_00_00_00_00};
    vecs[6] = '{dut: 0, mask: 3'b100, gap: 3, n: 4, b: 64'hA5_FF_00_FF_00_00_00_00};

    rst   = 1'b1;
    words = WORDS0;
    mask  = 3'b111;
    for (int d = 0; d < 3; d++) begin
      start_i[d]   = 1'b0;
      tx_done_i[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d_tx_start", d), tx_start_o[d], 0);
      check($sformatf("rst%0d_tx_data", d), tx_data_o[d], 0);
      check($sformatf("rst%0d_busy", d), busy_o[d], 0);
      check($sformatf("rst%0d_done", d), done_o[d], 0);
      check($sformatf("rst%0d_frame_bytes", d), frame_o[d], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      mask = vecs[v].mask;
      run_frame(vecs[v].dut, vecs[v].gap, 1'b0, 0);
      check_frame($sformatf("vec%0d", v), vecs[v].dut, vecs[v].n, vecs[v].b);
    end

    // Restart request and input churn while the third byte is in flight.
    mask = 3'b111;
    run_frame(0, 5, 1'b1, 0);
    check_frame("snapshot", 0, 8, vecs[0].b);
    words = WORDS0;
    mask  = 3'b111;

    // Reset while waiting on byte 4, then a clean frame.
    run_frame(0, 5, 1'b0, 4);
    check("abort_count", r_n, 4);
    check("abort_done_pulses", r_dones, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("abort_byte%0d", i), got[i], vecs[0].b[63-8*i -: 8]);
    run_frame(0, 5, 1'b0, 0);
    check_frame("after_abort", 0, 8, vecs[0].b);

    // Stray i_tx_done while idle, then a very slow UART.
    mask  = 3'b010;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      tx_done_i[1] = i[0];
      @(negedge clk);
      if (tx_start_o[1] || busy_o[1]) stray++;
    end
    tx_done_i[1] = 1'b0;
    check("idle_tx_done_ignored", stray, 0);
    run_frame(1, 1000, 1'b0, 0);
    check_frame("slow_uart", 1, 4, vecs[1].b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
